// File: rtl/free_list.sv
// Physical-register free list: circular buffer with wrap-bit pointers and per-ROB head snapshots.
// Optional FL_BYPASS_EN: a release into an empty list is allocatable in the same cycle.
module free_list #(
    parameter int NUM_PR  = 64,
    parameter int NUM_FL  = 32,
    parameter int NUM_ROB = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       dispatch_en,
    input  logic                       alloc_req,
    input  logic [$clog2(NUM_ROB)-1:0] dispatch_ROB_idx,
    input  logic                       retire_en,
    input  logic                       release_en,
    input  logic [$clog2(NUM_PR)-1:0]  Told_idx,
    input  logic                       rollback_en,
    input  logic [$clog2(NUM_ROB)-1:0] ROB_rollback_idx,
    output logic [$clog2(NUM_PR)-1:0]  T_idx,
    output logic                       FL_valid,
    output logic [$clog2(NUM_FL):0]    free_count
);
    localparam int PW = $clog2(NUM_PR);
    localparam int FW = $clog2(NUM_FL);

    typedef logic [FW:0] ptr_t;

    ptr_t          head, tail, head_post;
    logic [PW-1:0] entry [NUM_FL];
    ptr_t          snap  [NUM_ROB];
    logic          empty, full, push, pop, bypass;

    assign free_count = tail - head;
    assign empty      = (free_count == '0);
    assign full       = (free_count == ptr_t'(NUM_FL));
    // A release into a full list is dropped so the ring never overruns the head.
    assign push       = en && retire_en && release_en && !full;

`ifdef FL_BYPASS_EN
    assign bypass = empty && push;
`else
    assign bypass = 1'b0;
`endif

    assign FL_valid  = (!empty || bypass) && !rollback_en;
    assign T_idx     = bypass ? Told_idx : entry[head[FW-1:0]];
    assign pop       = en && dispatch_en && alloc_req && FL_valid;
    assign head_post = head + ptr_t'(pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= ptr_t'(NUM_FL);
            for (int i = 0; i < NUM_FL; i++)
                entry[i] <= PW'(NUM_PR - NUM_FL + i);
            for (int i = 0; i < NUM_ROB; i++)
                snap[i] <= '0;
        end else if (en) begin
            // FL_valid is low during rollback, so head_post == head then.
            head <= rollback_en ? snap[ROB_rollback_idx] : head_post;
            if (push) begin
                entry[tail[FW-1:0]] <= Told_idx;
                tail                <= tail + ptr_t'(1);
            end
            if (dispatch_en)
                snap[dispatch_ROB_idx] <= head_post;
        end
    end

`ifndef SYNTHESIS
    release_while_full: assert property (@(posedge clock) disable iff (reset)
        !(en && retire_en && release_en && full));
`endif

endmodule
